// File: rtl/conv_frame_sequencer.sv
// Frame sequencer for conv_engine_2d: starts the engine per frame, streams pixels
// from memory (one-cycle read latency), captures results and supervises completion.
module conv_frame_sequencer #(
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32,
    parameter int OUT_COUNT  = (IMG_WIDTH - 2) * (IMG_HEIGHT - 2),
    parameter int ADDR_W     = 16,
    parameter int TIMEOUT    = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_start,
    input  logic                     cmd_abort,
    input  logic [ADDR_W-1:0]        cmd_in_base,
    input  logic [ADDR_W-1:0]        cmd_out_base,
    input  logic [7:0]               cmd_num_frames,
    input  logic                     feed_pause,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic [7:0]               rd_data,
    output logic                     eng_start,
    output logic                     eng_pixel_valid,
    output logic [7:0]               eng_pixel_in,
    input  logic signed [21:0]       eng_result_out,
    input  logic                     eng_result_valid,
    input  logic                     eng_done,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic signed [21:0]       wr_data,
    output logic                     busy,
    output logic                     done,
    output logic [7:0]               frame_count,
    output logic                     err_timeout,
    output logic                     err_count,
    output logic                     err_spurious
);

    localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
    localparam int IDX_W = $clog2(NPIX + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_PIX = IDX_W'(NPIX - 1);
    localparam logic [IDX_W-1:0] RES_MAX  = IDX_W'(OUT_COUNT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_FEED  = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d, state_nat_s;
    logic [ADDR_W-1:0]   in_base_q, out_base_q;
    logic [7:0]          frames_left_q, frame_count_q;
    logic [IDX_W-1:0]    pix_idx_q, res_idx_q;
    logic [TMO_W-1:0]    tmo_q;
    logic                busy_q, done_q, eng_start_q, pix_valid_q;
    logic                wr_en_q;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic signed [21:0]  wr_data_q;
    logic                err_timeout_q, err_count_q, err_spurious_q;
    logic                rd_en_s, accept_s, capture_s, tmo_hit_s;

    // Reads are issued combinationally so a pause stalls the very cycle it is seen.
    assign rd_en_s   = (state_q == S_FEED) && !feed_pause;
    assign accept_s  = (state_q == S_IDLE) && cmd_start && !cmd_abort;
    assign capture_s = (state_q == S_START) || (state_q == S_FEED) || (state_q == S_WAIT);
    assign tmo_hit_s = (tmo_q == TMO_LAST);

    // Next-state decode; abort overrides every natural transition.
    always_comb begin
        state_nat_s = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_nat_s = (cmd_num_frames == 8'd0) ? S_DONE : S_START;
                end else begin
                    state_nat_s = S_IDLE;
                end
            end
            S_START: state_nat_s = S_FEED;
            S_FEED: begin
                if (rd_en_s && (pix_idx_q == LAST_PIX)) begin
                    state_nat_s = S_WAIT;
                end else begin
                    state_nat_s = S_FEED;
                end
            end
            S_WAIT: begin
                if (eng_done) begin
                    state_nat_s = (frames_left_q == 8'd1) ? S_DONE : S_START;
                end else if (tmo_hit_s) begin
                    state_nat_s = S_DONE;
                end else begin
                    state_nat_s = S_WAIT;
                end
            end
            S_DONE:  state_nat_s = S_IDLE;
            default: state_nat_s = S_IDLE;
        endcase
        if (cmd_abort) begin
            state_d = S_IDLE;
        end else begin
            state_d = state_nat_s;
        end
    end

    // Sequencer state, counters, registered outputs and result write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            in_base_q      <= {ADDR_W{1'b0}};
            out_base_q     <= {ADDR_W{1'b0}};
            frames_left_q  <= 8'd0;
            frame_count_q  <= 8'd0;
            pix_idx_q      <= {IDX_W{1'b0}};
            res_idx_q      <= {IDX_W{1'b0}};
            tmo_q          <= {TMO_W{1'b0}};
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            eng_start_q    <= 1'b0;
            pix_valid_q    <= 1'b0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= {ADDR_W{1'b0}};
            wr_data_q      <= 22'sd0;
            err_timeout_q  <= 1'b0;
            err_count_q    <= 1'b0;
            err_spurious_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_DONE);
            eng_start_q <= (state_d == S_START);
            pix_valid_q <= rd_en_s && !cmd_abort;
            wr_en_q     <= 1'b0;

            if (rd_en_s) pix_idx_q <= pix_idx_q + IDX_W'(1);
            if (state_q == S_FEED) tmo_q <= {TMO_W{1'b0}};
            else if (state_q == S_WAIT) tmo_q <= tmo_q + TMO_W'(1);

            if (accept_s) begin
                in_base_q      <= cmd_in_base;
                out_base_q     <= cmd_out_base;
                frames_left_q  <= cmd_num_frames;
                frame_count_q  <= 8'd0;
                err_timeout_q  <= 1'b0;
                err_count_q    <= 1'b0;
                err_spurious_q <= 1'b0;
            end

            if (eng_result_valid) begin
                if (capture_s) begin
                    if (res_idx_q < RES_MAX) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= out_base_q + ADDR_W'(res_idx_q);
                        wr_data_q <= eng_result_out;
                        res_idx_q <= res_idx_q + IDX_W'(1);
                    end else begin
                        err_count_q <= 1'b1;
                    end
                end else begin
                    err_spurious_q <= 1'b1;
                end
            end

            if (state_q == S_WAIT) begin
                if (eng_done) begin
                    frame_count_q <= frame_count_q + 8'd1;
                    frames_left_q <= frames_left_q - 8'd1;
                    in_base_q     <= in_base_q + ADDR_W'(NPIX);
                    out_base_q    <= out_base_q + ADDR_W'(OUT_COUNT);
                    if (res_idx_q != RES_MAX) err_count_q <= 1'b1;
                end else if (tmo_hit_s) begin
                    err_timeout_q <= 1'b1;
                end
            end

            // Entering START rearms the per-frame indices (wins over capture above).
            if (state_d == S_START) begin
                pix_idx_q <= {IDX_W{1'b0}};
                res_idx_q <= {IDX_W{1'b0}};
            end
        end
    end

    assign rd_en           = rd_en_s;
    assign rd_addr         = in_base_q + ADDR_W'(pix_idx_q);
    assign eng_start       = eng_start_q;
    assign eng_pixel_valid = pix_valid_q;
    assign eng_pixel_in    = pix_valid_q ? rd_data : 8'd0;
    assign wr_en           = wr_en_q;
    assign wr_addr         = wr_addr_q;
    assign wr_data         = wr_data_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign frame_count     = frame_count_q;
    assign err_timeout     = err_timeout_q;
    assign err_count       = err_count_q;
    assign err_spurious    = err_spurious_q;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Directed bench for conv_frame_sequencer with a pixel memory model, a behavioural
// engine model and bus monitors; expected values are hand-derived constants.
module tb_conv_frame_sequencer;

    logic               clk, rst;
    logic               cmd_start, cmd_abort;
    logic [15:0]        cmd_in_base, cmd_out_base;
    logic [7:0]         cmd_num_frames;
    logic               feed_pause;
    logic               rd_en;
    logic [15:0]        rd_addr;
    logic [7:0]         rd_data;
    logic               eng_start, eng_pixel_valid;
    logic [7:0]         eng_pixel_in;
    logic signed [21:0] eng_result_out;
    logic               eng_result_valid, eng_done;
    logic               wr_en;
    logic [15:0]        wr_addr;
    logic signed [21:0] wr_data;
    logic               busy, done;
    logic [7:0]         frame_count;
    logic               err_timeout, err_count, err_spurious;

    int n_pass = 0;
    int n_total = 0;

    conv_frame_sequencer dut (
        .clk(clk), .rst(rst),
        .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .cmd_in_base(cmd_in_base), .cmd_out_base(cmd_out_base),
        .cmd_num_frames(cmd_num_frames), .feed_pause(feed_pause),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .eng_start(eng_start), .eng_pixel_valid(eng_pixel_valid), .eng_pixel_in(eng_pixel_in),
        .eng_result_out(eng_result_out), .eng_result_valid(eng_result_valid), .eng_done(eng_done),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .frame_count(frame_count),
        .err_timeout(err_timeout), .err_count(err_count), .err_spurious(err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pix_of(input logic [15:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    function automatic logic signed [21:0] rv(input int n);
        return 22'(1000 - n * 37);
    endfunction

    // Pixel memory: one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en) rd_data <= pix_of(rd_addr);
        else       rd_data <= 8'h00;
    end

    // Engine model: after 1024 pixels emits eng_n results, then done unless hung.
    int  eng_n = 900;
    bit  eng_hang = 1'b0;
    int  pc, rc, em_cnt;
    bit  act;
    always @(posedge clk) begin
        eng_result_valid <= 1'b0;
        eng_done         <= 1'b0;
        if (rst) begin
            act <= 1'b0; pc <= 0; rc <= 0; em_cnt <= 0;
        end else if (eng_start) begin
            act <= 1'b1; pc <= 0; rc <= 0;
        end else if (act) begin
            if (eng_pixel_valid) pc <= pc + 1;
            if (pc == 1024) begin
                if (rc < eng_n) begin
                    eng_result_valid <= 1'b1;
                    eng_result_out   <= rv(em_cnt);
                    em_cnt <= em_cnt + 1;
                    rc <= rc + 1;
                end else begin
                    if (!eng_hang) eng_done <= 1'b1;
                    act <= 1'b0;
                end
            end
        end
    end

    // Bus monitors sampled on the falling edge.
    int rd_cnt, rd_bad, pix_cnt, pix_bad, wr_cnt, wr_bad, start_cnt, done_cnt;
    int first_rd, last_rd, first_wr, last_wr, cur_gap, gaps, last_gap;
    int cyc, last_rd_cyc, done_cyc;
    bit prev_rd_en;
    logic [15:0] prev_rd_addr;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            rd_cnt <= 0; rd_bad <= 0; pix_cnt <= 0; pix_bad <= 0; wr_cnt <= 0; wr_bad <= 0;
            start_cnt <= 0; done_cnt <= 0; cur_gap <= 0; gaps <= 0; last_gap <= 0;
            prev_rd_en <= 1'b0; first_rd <= -1; last_rd <= -1; first_wr <= -1; last_wr <= -1;
        end else begin
            if (rd_en) begin
                if (rd_cnt == 0) first_rd <= int'(rd_addr);
                else if (int'(rd_addr) != last_rd + 1) rd_bad <= rd_bad + 1;
                last_rd <= int'(rd_addr);
                rd_cnt <= rd_cnt + 1;
                last_rd_cyc <= cyc;
            end
            if (eng_pixel_valid) begin
                if (!prev_rd_en || eng_pixel_in !== pix_of(prev_rd_addr)) pix_bad <= pix_bad + 1;
                pix_cnt <= pix_cnt + 1;
                if (cur_gap > 0) begin gaps <= gaps + 1; last_gap <= cur_gap; end
                cur_gap <= 0;
            end else if (pix_cnt % 1024 != 0) begin
                cur_gap <= cur_gap + 1;
            end
            if (wr_en) begin
                if (wr_data !== rv(wr_cnt)) wr_bad <= wr_bad + 1;
                if (wr_cnt == 0) first_wr <= int'(wr_addr);
                else if (int'(wr_addr) != last_wr + 1) wr_bad <= wr_bad + 1;
                last_wr <= int'(wr_addr);
                wr_cnt <= wr_cnt + 1;
            end
            if (eng_start) start_cnt <= start_cnt + 1;
            if (done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
            prev_rd_en   <= rd_en;
            prev_rd_addr <= rd_addr;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic issue(input logic [15:0] ib, input logic [15:0] ob, input logic [7:0] nf);
        cmd_in_base = ib; cmd_out_base = ob; cmd_num_frames = nf; cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, input string tag);
        int n = 0;
        while (done !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    function automatic logic [31:0] outs_vec();
        return {busy, done, rd_en, eng_start, eng_pixel_valid, wr_en,
                err_timeout, err_count, err_spurious, frame_count, eng_pixel_in, 3'b000};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; cmd_start = 1'b0; cmd_abort = 1'b0; feed_pause = 1'b0;
        cmd_in_base = 16'h0; cmd_out_base = 16'h0; cmd_num_frames = 8'd0;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_outputs", outs_vec(), 32'd0);
        chk("reset_rd_addr", 32'(rd_addr), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single frame, in 0, out 0x200
        issue(16'h0000, 16'h0200, 8'd1);
        chk("t1_eng_start", 32'(eng_start), 32'd1);
        chk("t1_busy_rise", 32'(busy), 32'd1);
        @(negedge clk);
        chk("t1_start_1cyc", 32'(eng_start), 32'd0);
        chk("t1_first_rd", {15'd0, rd_en, rd_addr}, {15'd0, 1'b1, 16'h0000});
        @(negedge clk);
        chk("t1_pix0", {23'd0, eng_pixel_valid, eng_pixel_in}, {23'd0, 1'b1, 8'h00});
        wait_done(3000, "t1_done");
        @(negedge clk);
        chk("t1_done_drop", {30'd0, done, busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk("t1_starts", 32'(start_cnt), 32'd1);
        chk("t1_reads", 32'(rd_cnt), 32'd1024);
        chk("t1_rd_span", {first_rd[15:0], last_rd[15:0]}, {16'd0, 16'd1023});
        chk("t1_pixels", 32'(pix_cnt), 32'd1024);
        chk("t1_pix_bad", 32'(pix_bad + rd_bad), 32'd0);
        chk("t1_writes", 32'(wr_cnt), 32'd900);
        chk("t1_wr_span", {first_wr[15:0], last_wr[15:0]}, {16'h0200, 16'h0583});
        chk("t1_wr_bad", 32'(wr_bad), 32'd0);
        chk("t1_frame_count", 32'(frame_count), 32'd1);
        chk("t1_errors", {29'd0, err_timeout, err_count, err_spurious}, 32'd0);
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);

        // Three frames, out 0x1000
        do_reset();
        issue(16'h0000, 16'h1000, 8'd3);
        wait_done(10000, "t2_done");
        repeat (3) @(negedge clk);
        chk("t2_starts", 32'(start_cnt), 32'd3);
        chk("t2_rd_span", {first_rd[15:0], last_rd[15:0]}, {16'd0, 16'd3071});
        chk("t2_writes", 32'(wr_cnt), 32'd2700);
        chk("t2_wr_span", {first_wr[15:0], last_wr[15:0]}, {16'h1000, 16'h1A8B});
        chk("t2_bad", 32'(rd_bad + pix_bad + wr_bad), 32'd0);
        chk("t2_frame_count", 32'(frame_count), 32'd3);
        chk("t2_errors", {29'd0, err_timeout, err_count, err_spurious}, 32'd0);

        // Five-cycle feed pause mid-frame
        do_reset();
        issue(16'h0400, 16'h0000, 8'd1);
        repeat (200) @(negedge clk);
        feed_pause = 1'b1;
        repeat (5) @(negedge clk);
        feed_pause = 1'b0;
        wait_done(3000, "t3_done");
        repeat (3) @(negedge clk);
        chk("t3_gaps", 32'(gaps), 32'd1);
        chk("t3_gap_len", 32'(last_gap), 32'd5);
        chk("t3_pixels", 32'(pix_cnt), 32'd1024);
        chk("t3_order", 32'(pix_bad + rd_bad), 32'd0);
        chk("t3_first_rd", 32'(first_rd), 32'h0400);

        // Engine never signals done: timeout skips remaining frame
        do_reset();
        eng_hang = 1'b1;
        issue(16'h0000, 16'h0000, 8'd2);
        wait_done(7000, "t4_done");
        repeat (3) @(negedge clk);
        chk("t4_err_timeout", 32'(err_timeout), 32'd1);
        chk("t4_err_count", 32'(err_count), 32'd0);
        chk("t4_starts", 32'(start_cnt), 32'd1);
        chk("t4_frame_count", 32'(frame_count), 32'd0);
        chk("t4_latency", 32'(done_cyc - last_rd_cyc), 32'd4097);
        eng_hang = 1'b0;

        // Short result count
        do_reset();
        eng_n = 899;
        issue(16'h0000, 16'h0000, 8'd1);
        wait_done(3000, "t5_done");
        repeat (3) @(negedge clk);
        chk("t5_err_count", {30'd0, err_count, err_timeout}, {30'd0, 1'b1, 1'b0});
        chk("t5_writes", 32'(wr_cnt), 32'd899);

        // Excess result count
        do_reset();
        eng_n = 901;
        issue(16'h0000, 16'h0100, 8'd1);
        wait_done(3000, "t6_done");
        repeat (3) @(negedge clk);
        chk("t6_err_count", 32'(err_count), 32'd1);
        chk("t6_writes", 32'(wr_cnt), 32'd900);
        chk("t6_last_wr", 32'(last_wr), 32'h0100 + 32'd899);
        eng_n = 900;

        // Abort mid-FEED, start+abort collision, async reset mid-WAIT_DONE
        do_reset();
        issue(16'h0000, 16'h0000, 8'd2);
        repeat (100) @(negedge clk);
        chk("t7_busy_feed", {31'd0, rd_en}, 32'd1);
        cmd_abort = 1'b1;
        @(negedge clk);
        cmd_abort = 1'b0;
        chk("t7_abort_idle", {29'd0, busy, rd_en, eng_pixel_valid}, 32'd0);
        repeat (20) @(negedge clk);
        chk("t7_no_done", 32'(done_cnt), 32'd0);
        cmd_start = 1'b1; cmd_abort = 1'b1; cmd_num_frames = 8'd1;
        @(negedge clk);
        cmd_start = 1'b0; cmd_abort = 1'b0;
        chk("t7_abort_wins", {30'd0, busy, eng_start}, 32'd0);
        issue(16'h0000, 16'h0000, 8'd1);
        repeat (1100) @(negedge clk);
        chk("t7_busy_wait", {30'd0, busy, rd_en}, {30'd0, 1'b1, 1'b0});
        #2 rst = 1'b1;
        #1 chk("t7_async_rst", outs_vec(), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(16'h0800, 16'h0300, 8'd1);
        wait_done(3000, "t7_fresh_done");
        repeat (3) @(negedge clk);
        chk("t7_fresh_errors", {29'd0, err_timeout, err_count, err_spurious}, 32'd0);
        chk("t7_fresh_writes", 32'(wr_cnt), 32'd900);
        chk("t7_fresh_first_rd", 32'(first_rd), 32'h0800);
        chk("t7_fresh_done_cnt", 32'(done_cnt), 32'd1);

        // Zero frames goes straight to DONE
        do_reset();
        issue(16'h0000, 16'h0000, 8'd0);
        chk("t8_zero_done", {29'd0, done, busy, eng_start}, {29'd0, 1'b1, 1'b1, 1'b0});
        @(negedge clk);
        chk("t8_zero_idle", {30'd0, done, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
